// File: rtl/sweep_controller.sv
`default_nettype none
// ============================================================================
// Module   : sweep_controller
// Purpose  : Sliding-LED reaction game core with scoring hold. Optional macro
//            SWEEP_PINGPONG_EN selects ping-pong motion instead of wrap-around.
// Revision : 1.0  initial release
// ============================================================================
module sweep_controller #(
  parameter int TARGET     = 0,
  parameter int HOLD_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       run,
  input  logic [6:0] diff,
  input  logic       hit,
  output logic [6:0] led,
  output logic [2:0] pos,
  output logic       hit_ok,
  output logic       miss
);

  localparam logic [2:0] c_TARGET    = 3'(TARGET);
  localparam logic [3:0] c_HOLD_LAST = 4'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] pos_q;
  logic [6:0] led_q;
  logic [3:0] cnt_q;
  logic [3:0] period_q;
  logic       dir_q;
  logic       hit_ok_q;
  logic       miss_q;

  logic [2:0] w_level;
  logic [3:0] w_period;
  logic [2:0] pos_d;
  logic       dir_d;
  logic [6:0] w_led_next;

  // Difficulty level is the highest set switch; higher level, shorter period.
  always_comb begin
    w_level = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (diff[i]) w_level = 3'(i + 1);
    end
    w_period = 4'd8 - {1'b0, w_level};
  end

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
`ifdef SWEEP_PINGPONG_EN
    if (!dir_q) begin
      if (pos_q == 3'd6) begin
        pos_d = 3'd5;
        dir_d = 1'b1;
      end else begin
        pos_d = pos_q + 3'd1;
      end
    end else begin
      if (pos_q == 3'd0) begin
        pos_d = 3'd1;
        dir_d = 1'b0;
      end else begin
        pos_d = pos_q - 3'd1;
      end
    end
`else
    pos_d = (pos_q == 3'd6) ? 3'd0 : pos_q + 3'd1;
`endif
    w_led_next = 7'b000_0001 << pos_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pos_q    <= 3'd0;
      led_q    <= 7'd0;
      cnt_q    <= 4'd0;
      period_q <= 4'd8;
      dir_q    <= 1'b0;
      hit_ok_q <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      hit_ok_q <= 1'b0;
      miss_q   <= 1'b0;
      if (!run) begin
        state_q <= ST_IDLE;
        pos_q   <= 3'd0;
        led_q   <= 7'd0;
        cnt_q   <= 4'd0;
        dir_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q  <= ST_SWEEP;
            pos_q    <= 3'd0;
            led_q    <= 7'b000_0001;
            cnt_q    <= 4'd0;
            dir_q    <= 1'b0;
            period_q <= w_period;
          end
          ST_SWEEP: begin
            // A scoring hit wins over a coincident step: position is frozen.
            if (hit && (pos_q == c_TARGET)) begin
              state_q  <= ST_HOLD;
              hit_ok_q <= 1'b1;
              cnt_q    <= 4'd0;
            end else begin
              miss_q <= hit;
              if (tick) begin
                if (cnt_q == period_q - 4'd1) begin
                  pos_q    <= pos_d;
                  led_q    <= w_led_next;
                  dir_q    <= dir_d;
                  cnt_q    <= 4'd0;
                  period_q <= w_period;
                end else begin
                  cnt_q <= cnt_q + 4'd1;
                end
              end
            end
          end
          ST_HOLD: begin
            if (tick) begin
              if (cnt_q == c_HOLD_LAST) begin
                state_q  <= ST_SWEEP;
                pos_q    <= 3'd0;
                led_q    <= 7'b000_0001;
                dir_q    <= 1'b0;
                cnt_q    <= 4'd0;
                period_q <= w_period;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign led    = led_q;
  assign pos    = pos_q;
  assign hit_ok = hit_ok_q;
  assign miss   = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sweep_controller
// Purpose  : Directed vector table plus multi-cycle sequences for sweep_controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_sweep_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       run = 1'b0;
  logic [6:0] diff = 7'd0;
  logic       hit = 1'b0;
  logic [6:0] led;
  logic [2:0] pos;
  logic       hit_ok;
  logic       miss;

  int n_cmp = 0;
  int n_err = 0;

  sweep_controller #(.TARGET(0), .HOLD_TICKS(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .run    (run),
    .diff   (diff),
    .hit    (hit),
    .led    (led),
    .pos    (pos),
    .hit_ok (hit_ok),
    .miss   (miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       run;
    logic [6:0] diff;
    logic       tick;
    logic       hit;
    logic [6:0] led;
    logic [2:0] pos;
    logic       ok;
    logic       miss;
  } vec_t;

  vec_t vecs[20];
  int   exp_b[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] onehot(input int p);
    logic [6:0] one;
    one = 7'b000_0001;
    return one << p;
  endfunction

  task automatic check(input string name, input logic [6:0] led_e, input logic [2:0] pos_e,
                       input logic ok_e, input logic miss_e);
    n_cmp++;
    if ({led, pos, hit_ok, miss} !== {led_e, pos_e, ok_e, miss_e}) begin
      n_err++;
      $display("FAIL %s: got led=%b pos=%0d hit_ok=%b miss=%b, want led=%b pos=%0d hit_ok=%b miss=%b",
               name, led, pos, hit_ok, miss, led_e, pos_e, ok_e, miss_e);
    end
  endtask

  task automatic restart(input logic [6:0] d);
    reset = 1'b1; run = 1'b0; tick = 1'b0; hit = 1'b0; diff = d;
    step();
    reset = 1'b0; run = 1'b1;
    step();
    check("enter_sweep", 7'b000_0001, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    //         rst run diff      tick hit  led          pos   ok   miss
    vecs[0]  = '{1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 7'h40, 1'b0, 1'b0, 7'h00, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 7'h40, 1'b0, 1'b0, 7'h01, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 7'h02, 3'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b1, 7'h04, 3'd2, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 7'h40, 1'b0, 1'b0, 7'h04, 3'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 7'h08, 3'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 7'h10, 3'd4, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 7'h20, 3'd5, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 7'h40, 3'd6, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 7'h40, 1'b1, 1'b0, 7'h00, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 7'h40, 1'b0, 1'b0, 7'h01, 3'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b1, 7'h01, 3'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b1, 7'h01, 3'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 7'h01, 3'd0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 7'h01, 3'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 7'h01, 3'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 7'h02, 3'd1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 7'h40, 1'b0, 1'b1, 7'h02, 3'd1, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 7'h40, 1'b0, 1'b1, 7'h00, 3'd0, 1'b0, 1'b0};
`ifdef SWEEP_PINGPONG_EN
    exp_b = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 1, 2};
`else
    exp_b = '{1, 2, 3, 4, 5, 6, 0, 1, 2, 3, 4, 5, 6, 0};
`endif

    for (int i = 0; i < 20; i++) begin
      reset = vecs[i].rst; run = vecs[i].run; diff = vecs[i].diff;
      tick = vecs[i].tick; hit = vecs[i].hit;
      step();
      check($sformatf("vec%0d", i), vecs[i].led, vecs[i].pos, vecs[i].ok, vecs[i].miss);
    end

    // Slowest level, tick every 4 clk: one step per 8 ticks; miss at pos 3.
    restart(7'h00);
    for (int k = 1; k <= 48; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      check($sformatf("slow_tick%0d", k), onehot((k / 8) % 7), 3'((k / 8) % 7), 1'b0, 1'b0);
      if (k == 25) begin
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("miss_pos3", 7'b000_1000, 3'd3, 1'b0, 1'b1);
        step();
        step();
      end else begin
        step(); step(); step();
      end
    end

    // Fastest level, one step per tick.
    restart(7'h40);
    tick = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      check($sformatf("fast%0d", k), onehot(exp_b[k]), 3'(exp_b[k]), 1'b0, 1'b0);
    end
    tick = 1'b0;

    // Period 5 latched at entry; a diff change only applies after the next step.
    restart(7'b000_0101);
    tick = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 3) diff = 7'h00;
      step();
      if (k < 5)       check($sformatf("per_t%0d", k), 7'h01, 3'd0, 1'b0, 1'b0);
      else if (k < 13) check($sformatf("per_t%0d", k), 7'h02, 3'd1, 1'b0, 1'b0);
      else             check("per_t13", 7'h04, 3'd2, 1'b0, 1'b0);
    end
    tick = 1'b0;

    // Scoring hit pulse width, then reset while holding.
    restart(7'h40);
    hit = 1'b1;
    step();
    hit = 1'b0;
    check("score_pulse", 7'h01, 3'd0, 1'b1, 1'b0);
    step();
    check("score_one_clk", 7'h01, 3'd0, 1'b0, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("hold_frozen", 7'h01, 3'd0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    check("reset_in_hold", 7'h00, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check("resume_after_reset", 7'h01, 3'd0, 1'b0, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("sweep_after_reset", 7'h02, 3'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
